midi_voice_allocator: RTL and testbench

- Polyphonic voice scheduler between the MIDI byte parser and the per-voice divider/envelope datapath.
- Accepts decoded note-on/note-off events and assigns each note-on to one of NUM_VOICES voices: retrigger, free voice, or LRU steal.
- Sequences the shared note-divider LUT to load the assigned voice's divider, and releases the matching voice on note-off.

---
 rtl/midi_voice_allocator.sv | 162 ++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: retrigger, free voice or LRU steal on note-on, gate release on note-off.
// Optional feature macro: VOICE_STEAL_EN (defined = steal LRU voice; undefined = drop note when full).
module midi_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int D_W        = 16,
  parameter int BYTE_W     = 8
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic                      ev_on,
  input  logic [6:0]                ev_note,
  input  logic [6:0]                ev_vel,
  output logic [BYTE_W-1:0]         lut_addr,
  input  logic [D_W-1:0]            lut_data,
  output logic [NUM_VOICES-1:0]     voice_gate,
  output logic [NUM_VOICES*7-1:0]   voice_note,
  output logic [NUM_VOICES*D_W-1:0] voice_div,
  output logic                      ev_done,
  output logic                      steal_strobe,
  output logic [1:0]                fsm_state
);
  localparam int RW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_LUT_WAIT, S_COMMIT} state_t;

  // Handshake: an event transfers on a rising edge where ev_valid && ev_ready;
  // ev_ready is high only in IDLE and upstream holds the event until then.
  state_t state, state_nx;

  logic                  on_q, hit_q, steal_q;
  logic [6:0]            note_q;
  logic [RW-1:0]         tgt_q;
  logic [D_W-1:0]        div_q;
  logic [BYTE_W-1:0]     lut_addr_q;
  logic [NUM_VOICES-1:0] gate_q;
  logic [6:0]            note_arr [NUM_VOICES];
  logic [D_W-1:0]        div_arr  [NUM_VOICES];
  logic [RW-1:0]         rank     [NUM_VOICES];

  logic          match_found, free_found, sel_hit, sel_steal;
  logic [RW-1:0] match_idx, free_idx, old_idx, sel_idx;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    old_idx     = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (gate_q[v] && note_arr[v] == note_q) begin
        match_found = 1'b1;
        match_idx   = RW'(v);
      end
      if (!gate_q[v]) begin
        free_found = 1'b1;
        free_idx   = RW'(v);
      end
      if (rank[v] == RW'(NUM_VOICES - 1)) old_idx = RW'(v);
    end
  end

  always_comb begin
    sel_idx   = match_idx;
    sel_hit   = match_found;
    sel_steal = 1'b0;
    if (on_q && !match_found) begin
      if (free_found) begin
        sel_idx = free_idx;
        sel_hit = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        sel_idx   = old_idx;
        sel_hit   = 1'b1;
        sel_steal = 1'b1;
`else
        // All voices busy: the note is dropped and the strobe flags the drop.
        sel_idx   = old_idx;
        sel_hit   = 1'b0;
        sel_steal = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (ev_valid) state_nx = S_SEARCH;
      S_SEARCH:   state_nx = (on_q && sel_hit) ? S_LUT_WAIT : S_COMMIT;
      S_LUT_WAIT: state_nx = S_COMMIT;
      S_COMMIT:   state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ev_ready     = (state == S_IDLE);
    ev_done      = (state == S_COMMIT);
    steal_strobe = (state == S_COMMIT) && steal_q;
    fsm_state    = state;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      on_q       <= 1'b0;
      hit_q      <= 1'b0;
      steal_q    <= 1'b0;
      note_q     <= '0;
      tgt_q      <= '0;
      div_q      <= '0;
      lut_addr_q <= '0;
      gate_q     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_arr[v] <= '0;
        div_arr[v]  <= '0;
        rank[v]     <= RW'(v);
      end
    end else begin
      if (state == S_IDLE && ev_valid) begin
        on_q   <= ev_on && (ev_vel != 7'd0);
        note_q <= ev_note;
        // Address is presented for the whole SEARCH cycle and then held.
        if (ev_on && ev_vel != 7'd0) lut_addr_q <= {{(BYTE_W-7){1'b0}}, ev_note};
      end
      if (state == S_SEARCH) begin
        tgt_q   <= sel_idx;
        hit_q   <= sel_hit;
        steal_q <= sel_steal;
      end
      if (state == S_LUT_WAIT) div_q <= lut_data;
      if (state == S_COMMIT && hit_q) begin
        if (on_q) begin
          gate_q[tgt_q]   <= 1'b1;
          note_arr[tgt_q] <= note_q;
          div_arr[tgt_q]  <= div_q;
          for (int v = 0; v < NUM_VOICES; v++)
            if (rank[v] < rank[tgt_q]) rank[v] <= rank[v] + RW'(1);
          rank[tgt_q] <= '0;
        end else begin
          gate_q[tgt_q] <= 1'b0;
        end
      end
    end
  end

  assign lut_addr   = lut_addr_q;
  assign voice_gate = gate_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[7*g +: 7]     = note_arr[g];
    assign voice_div[D_W*g +: D_W]  = div_arr[g];
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator with a registered note-divider LUT model.
// Build with or without +define+VOICE_STEAL_EN; expectations follow the macro.
module tb_midi_voice_allocator;
  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic [6:0]  ev_vel = '0;
  logic [7:0]  lut_addr;
  logic [15:0] lut_data = '0;
  logic [3:0]  voice_gate;
  logic [27:0] voice_note;
  logic [63:0] voice_div;
  logic        ev_done;
  logic        steal_strobe;
  logic [1:0]  fsm_state;

  int compared = 0;
  int mismatched = 0;

  midi_voice_allocator #(.NUM_VOICES(4), .D_W(16), .BYTE_W(8)) dut (
    .sys_clk(sys_clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_vel(ev_vel), .lut_addr(lut_addr),
    .lut_data(lut_data), .voice_gate(voice_gate), .voice_note(voice_note),
    .voice_div(voice_div), .ev_done(ev_done), .steal_strobe(steal_strobe),
    .fsm_state(fsm_state)
  );

  always #5 sys_clk = ~sys_clk;

  // Divider table: 0x1234 at note 60, stepping 0x10 per semitone.
  function automatic logic [15:0] lut_f(input logic [7:0] a);
    return 16'h1234 + ((16'(a) - 16'd60) << 4);
  endfunction

  always @(posedge sys_clk) lut_data <= lut_f(lut_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
  endtask

  task automatic send(input string tag, input logic on, input logic [6:0] note,
                      input logic [6:0] vel, input int exp_lat, input logic exp_steal);
    int w = 0;
    int lat = -1;
    logic stl = 1'b0;
    @(negedge sys_clk);
    while (!ev_ready && w < 20) begin
      @(negedge sys_clk);
      w++;
    end
    chk({tag, "_ready_in"}, ev_ready, 1'b1);
    ev_valid = 1'b1;
    ev_on = on;
    ev_note = note;
    ev_vel = vel;
    @(posedge sys_clk);
    #1 ev_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge sys_clk);
      if (n == 1) chk({tag, "_ready_low"}, ev_ready, 1'b0);
      if (ev_done && lat < 0) begin
        lat = n;
        stl = steal_strobe;
      end else if (lat > 0 && n == lat + 1) begin
        chk({tag, "_ready_back"}, ev_ready, 1'b1);
        chk({tag, "_done_pulse"}, ev_done, 1'b0);
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_steal"}, stl, exp_steal);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge sys_clk);
    chk("rst_ready", ev_ready, 1'b1);
    chk("rst_gate", voice_gate, 4'b0000);
    chk("rst_note", voice_note, 28'h0);
    chk("rst_div", voice_div, 64'h0);
    chk("rst_done", ev_done, 1'b0);
    chk("rst_steal", steal_strobe, 1'b0);
    chk("rst_lut", lut_addr, 8'h00);
    chk("rst_state", fsm_state, 2'd0);
    rst = 1'b0;

    // First note-on lands in voice 0
    send("on60", 1'b1, 7'd60, 7'd100, 3, 1'b0);
    chk("on60_gate", voice_gate, 4'b0001);
    chk("on60_note", voice_note[6:0], 7'd60);
    chk("on60_div", voice_div[15:0], 16'h1234);
    chk("on60_lut", lut_addr, 8'd60);

    // Fill remaining voices, then release note 64
    send("on64", 1'b1, 7'd64, 7'd90, 3, 1'b0);
    send("on67", 1'b1, 7'd67, 7'd80, 3, 1'b0);
    send("on72", 1'b1, 7'd72, 7'd70, 3, 1'b0);
    chk("chord_gate", voice_gate, 4'b1111);
    chk("chord_notes", voice_note, {7'd72, 7'd67, 7'd64, 7'd60});
    chk("chord_div3", voice_div[63:48], 16'h12f4);
    send("off64", 1'b0, 7'd64, 7'd0, 2, 1'b0);
    chk("off64_gate", voice_gate, 4'b1101);
    chk("off64_note", voice_note[13:7], 7'd64);
    chk("off64_div", voice_div[31:16], 16'h1274);
    chk("off64_lut", lut_addr, 8'd72);

    // All voices busy: steal or drop
    do_reset();
    send("f60", 1'b1, 7'd60, 7'd100, 3, 1'b0);
    send("f62", 1'b1, 7'd62, 7'd100, 3, 1'b0);
    send("f64", 1'b1, 7'd64, 7'd100, 3, 1'b0);
    send("f65", 1'b1, 7'd65, 7'd100, 3, 1'b0);
`ifdef VOICE_STEAL_EN
    send("st67", 1'b1, 7'd67, 7'd100, 3, 1'b1);
    chk("st67_gate", voice_gate, 4'b1111);
    chk("st67_notes", voice_note, {7'd65, 7'd64, 7'd62, 7'd67});
    chk("st67_div", voice_div[15:0], lut_f(8'd67));
    send("st69", 1'b1, 7'd69, 7'd100, 3, 1'b1);
    chk("st69_notes", voice_note, {7'd65, 7'd64, 7'd69, 7'd67});
    chk("st69_div", voice_div[31:16], lut_f(8'd69));
`else
    send("dr67", 1'b1, 7'd67, 7'd100, 2, 1'b1);
    chk("dr67_gate", voice_gate, 4'b1111);
    chk("dr67_notes", voice_note, {7'd65, 7'd64, 7'd62, 7'd60});
    chk("dr67_div", voice_div[15:0], 16'h1234);
`endif

    // Retrigger reuses the matching voice
    do_reset();
    send("rt60a", 1'b1, 7'd60, 7'd100, 3, 1'b0);
    send("rt60b", 1'b1, 7'd60, 7'd50, 3, 1'b0);
    chk("rt60_gate", voice_gate, 4'b0001);
    send("rt64a", 1'b1, 7'd64, 7'd100, 3, 1'b0);
    send("rt64b", 1'b1, 7'd64, 7'd100, 3, 1'b0);
    chk("rt64_gate", voice_gate, 4'b0011);
    chk("rt64_notes", voice_note[13:0], {7'd64, 7'd60});

    // Velocity 0 acts as note-off; unmatched note-off only completes
    send("v0_60", 1'b1, 7'd60, 7'd0, 2, 1'b0);
    chk("v0_gate", voice_gate, 4'b0010);
    chk("v0_note", voice_note[6:0], 7'd60);
    chk("v0_div", voice_div[15:0], 16'h1234);
    chk("v0_lut", lut_addr, 8'd64);
    send("off50", 1'b0, 7'd50, 7'd0, 2, 1'b0);
    chk("off50_gate", voice_gate, 4'b0010);
    chk("off50_notes", voice_note[13:0], {7'd64, 7'd60});

    // Reset during LUT_WAIT aborts the event
    @(negedge sys_clk);
    ev_valid = 1'b1;
    ev_on = 1'b1;
    ev_note = 7'd62;
    ev_vel = 7'd100;
    @(posedge sys_clk);
    #1 ev_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("mid_state", fsm_state, 2'd2);
    rst = 1'b1;
    #1;
    chk("mid_ready", ev_ready, 1'b1);
    chk("mid_gate", voice_gate, 4'b0000);
    chk("mid_note", voice_note, 28'h0);
    chk("mid_div", voice_div, 64'h0);
    chk("mid_lut", lut_addr, 8'h00);
    chk("mid_done", ev_done, 1'b0);
    chk("mid_state0", fsm_state, 2'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    send("post64", 1'b1, 7'd64, 7'd100, 3, 1'b0);
    chk("post_gate", voice_gate, 4'b0001);
    chk("post_note", voice_note[6:0], 7'd64);
    chk("post_div", voice_div[15:0], 16'h1274);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
